// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle fetch/control sequencer:
//   - MIPS opcode and R-type funct constants
//   - ALUctrl encodings understood by the single-cycle datapath
//   - sequencer state enum
//   - control-word struct (the selects held stable for one instruction)
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Opcodes, Inst[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // R-type funct codes, Inst[5:0]
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALUctrl encodings
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       mem_to_reg;
    } ctrl_word_t;

    // Selects presented while no instruction is executing
    localparam ctrl_word_t CTRL_IDLE = '{reg_dst: 1'b0, alu_src: 1'b0,
                                         alu_ctrl: ALU_ADD, mem_to_reg: 1'b0};

endpackage

// File: rtl/mips_ctrl_decoder.sv
// ---------------------------------------------------------------------------
// mips_ctrl_decoder
// Purely combinational decode of the instruction register fields.
// Ports:
//   opcode   in  6  Inst[31:26]
//   funct    in  6  Inst[5:0]
//   ctrl     out    control word (RegDst/ALUSrc/ALUctrl/MemToReg)
//   is_mem   out 1  lw or sw (instruction visits MEM)
//   is_load  out 1  lw
//   is_halt  out 1  HALT opcode
//   illegal  out 1  unsupported opcode or unknown R-type funct
// ---------------------------------------------------------------------------
module mips_ctrl_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output ctrl_word_t  ctrl,
    output logic        is_mem,
    output logic        is_load,
    output logic        is_halt,
    output logic        illegal
);

    // Opcode/funct decode; anything not listed falls through to illegal
    always_comb begin
        ctrl    = CTRL_IDLE;
        is_mem  = 1'b0;
        is_load = 1'b0;
        is_halt = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
                    FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
                    FN_AND:  ctrl.alu_ctrl = ALU_AND;
                    FN_OR:   ctrl.alu_ctrl = ALU_OR;
                    FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
                    default: begin
                        ctrl    = CTRL_IDLE;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                ctrl.alu_src = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                is_mem          = 1'b1;
                is_load         = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src = 1'b1;
                is_mem       = 1'b1;
            end
            OP_HALT: begin
                is_halt = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// mips_fetch_ctrl
// Multicycle fetch/control sequencer in front of a single-cycle datapath.
// Fetches a word over a req/ready handshake into IR, then walks the datapath
// through EXEC/MEM/WB so every storage write enable is high for one clock.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   imem_addr/imem_req    fetch address (= PC) and request
//   imem_data/imem_ready  fetched word and its valid strobe
//   Inst                  IR contents to datapath
//   RegDst, RegWrite, ALUSrc, ALUctrl, MemWrite, MemRead, MemToReg
//                         datapath controls, all registered
//   pc                    current PC
//   halted, fault         sticky status
// ---------------------------------------------------------------------------
module mips_fetch_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    output logic [31:0] Inst,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic [2:0]  ALUctrl,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToReg,
    output logic [31:0] pc,
    output logic        halted,
    output logic        fault
);

    localparam int unsigned         WAIT_W    = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);
    localparam logic [WAIT_W-1:0]   WAIT_ONE  = WAIT_W'(1);

    state_t             state_r;
    logic [31:0]        pc_r;
    logic [31:0]        ir_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic               imem_req_r;
    ctrl_word_t         ctrl_r;
    logic               reg_write_r;
    logic               mem_write_r;
    logic               mem_read_r;
    logic               halted_r;
    logic               fault_r;

    ctrl_word_t         dec_ctrl_s;
    logic               dec_is_mem_s;
    logic               dec_is_load_s;
    logic               dec_is_halt_s;
    logic               dec_illegal_s;

    mips_ctrl_decoder u_decoder (
        .opcode  (ir_r[31:26]),
        .funct   (ir_r[5:0]),
        .ctrl    (dec_ctrl_s),
        .is_mem  (dec_is_mem_s),
        .is_load (dec_is_load_s),
        .is_halt (dec_is_halt_s),
        .illegal (dec_illegal_s)
    );

    // Sequencer FSM with PC, IR, wait counter and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FETCH;
            pc_r        <= RESET_PC;
            ir_r        <= 32'h0000_0000;
            wait_cnt_r  <= '0;
            imem_req_r  <= 1'b1;    // reset lands in FETCH, which requests
            ctrl_r      <= CTRL_IDLE;
            reg_write_r <= 1'b0;
            mem_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            halted_r    <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ready) begin
                        ir_r       <= imem_data;
                        pc_r       <= pc_r + 32'd4;   // wraps mod 2^32
                        wait_cnt_r <= '0;
                        imem_req_r <= 1'b0;
                        state_r    <= ST_DECODE;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        // This is the WAIT_LIMIT-th cycle without ready
                        imem_req_r <= 1'b0;
                        halted_r   <= 1'b1;
                        fault_r    <= 1'b1;
                        state_r    <= ST_HALT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal_s) begin
                        halted_r <= 1'b1;
                        fault_r  <= 1'b1;
                        state_r  <= ST_HALT;
                    end else if (dec_is_halt_s) begin
                        halted_r <= 1'b1;
                        state_r  <= ST_HALT;
                    end else begin
                        ctrl_r  <= dec_ctrl_s;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Enables are armed here so they are high during MEM/WB
                    if (dec_is_mem_s) begin
                        mem_read_r  <= dec_is_load_s;
                        mem_write_r <= !dec_is_load_s;
                        state_r     <= ST_MEM;
                    end else begin
                        reg_write_r <= 1'b1;
                        state_r     <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dec_is_load_s) begin
                        reg_write_r <= 1'b1;         // MemRead stays high in WB
                        state_r     <= ST_WB;
                    end else begin
                        mem_write_r <= 1'b0;
                        ctrl_r      <= CTRL_IDLE;
                        imem_req_r  <= 1'b1;
                        state_r     <= ST_FETCH;
                    end
                end
                ST_WB: begin
                    reg_write_r <= 1'b0;
                    mem_read_r  <= 1'b0;
                    ctrl_r      <= CTRL_IDLE;
                    imem_req_r  <= 1'b1;
                    state_r     <= ST_FETCH;
                end
                ST_HALT: begin
                    imem_req_r  <= 1'b0;
                    ctrl_r      <= CTRL_IDLE;
                    reg_write_r <= 1'b0;
                    mem_write_r <= 1'b0;
                    mem_read_r  <= 1'b0;
                    halted_r    <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: park safely and flag it
                    imem_req_r  <= 1'b0;
                    ctrl_r      <= CTRL_IDLE;
                    reg_write_r <= 1'b0;
                    mem_write_r <= 1'b0;
                    mem_read_r  <= 1'b0;
                    halted_r    <= 1'b1;
                    fault_r     <= 1'b1;
                    state_r     <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_addr = pc_r;
    assign imem_req  = imem_req_r;
    assign Inst      = ir_r;
    assign pc        = pc_r;
    assign RegDst    = ctrl_r.reg_dst;
    assign ALUSrc    = ctrl_r.alu_src;
    assign ALUctrl   = ctrl_r.alu_ctrl;
    assign MemToReg  = ctrl_r.mem_to_reg;
    assign RegWrite  = reg_write_r;
    assign MemWrite  = mem_write_r;
    assign MemRead   = mem_read_r;
    assign halted    = halted_r;
    assign fault     = fault_r;

endmodule

// File: tb/tb_mips_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_ctrl
// Table-driven bench: each record is one instruction word run from reset
// with a zero-wait memory, with per-cycle enable masks (bit k = cycle k+1)
// and the expected selects. Hand sequences cover fetch timeout, wait
// states and reset during MEM.
// ---------------------------------------------------------------------------
module tb_mips_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic [31:0] Inst;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrc;
    logic [2:0]  ALUctrl;
    logic        MemWrite;
    logic        MemRead;
    logic        MemToReg;
    logic [31:0] pc;
    logic        halted;
    logic        fault;

    int errors = 0;
    int checks = 0;

    mips_fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_data  (imem_data),
        .imem_ready (imem_ready),
        .Inst       (Inst),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrc     (ALUSrc),
        .ALUctrl    (ALUctrl),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .MemToReg   (MemToReg),
        .pc         (pc),
        .halted     (halted),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] word;
        logic [5:0]  rw_m;    // RegWrite per cycle 1..6
        logic [5:0]  mr_m;    // MemRead
        logic [5:0]  mw_m;    // MemWrite
        logic [5:0]  ctrl3;   // {RegDst, ALUSrc, ALUctrl, MemToReg} in cycle 3
        logic [31:0] pc6;
        logic        halted;
        logic        fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [31:0] w,
                                input logic [5:0] rw, input logic [5:0] mr,
                                input logic [5:0] mw, input logic [5:0] c3,
                                input logic [31:0] p6, input logic h, input logic f);
        vec_t v;
        v.name = n; v.word = w; v.rw_m = rw; v.mr_m = mr; v.mw_m = mw;
        v.ctrl3 = c3; v.pc6 = p6; v.halted = h; v.fault = f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [5:0]  rw, mr, mw;
        logic [5:0]  c1, c3;
        logic [31:0] pc2, inst2, pc6;
        logic        req1, req2, h6, f6;
        logic [31:0] addr1;
        imem_data  = v.word;
        imem_ready = 1'b1;
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            rw[c-1] = RegWrite;
            mr[c-1] = MemRead;
            mw[c-1] = MemWrite;
            if (c == 1) begin
                req1  = imem_req;
                addr1 = imem_addr;
                c1    = {RegDst, ALUSrc, ALUctrl, MemToReg};
            end
            if (c == 2) begin
                req2  = imem_req;
                pc2   = pc;
                inst2 = Inst;
            end
            if (c == 3) c3 = {RegDst, ALUSrc, ALUctrl, MemToReg};
            if (c == 6) begin
                pc6 = pc;
                h6  = halted;
                f6  = fault;
            end
        end
        chk({v.name, " req_c1"},   32'(req1),  32'd1);
        chk({v.name, " addr_c1"},  addr1,      32'h0000_0000);
        chk({v.name, " ctrl_c1"},  32'(c1),    32'(6'b000100));
        chk({v.name, " req_c2"},   32'(req2),  32'd0);
        chk({v.name, " pc_c2"},    pc2,        32'h0000_0004);
        chk({v.name, " inst_c2"},  inst2,      v.word);
        chk({v.name, " regwrite"}, 32'(rw),    32'(v.rw_m));
        chk({v.name, " memread"},  32'(mr),    32'(v.mr_m));
        chk({v.name, " memwrite"}, 32'(mw),    32'(v.mw_m));
        chk({v.name, " ctrl_c3"},  32'(c3),    32'(v.ctrl3));
        chk({v.name, " pc_c6"},    pc6,        v.pc6);
        chk({v.name, " halted"},   32'(h6),    32'(v.halted));
        chk({v.name, " fault"},    32'(f6),    32'(v.fault));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        imem_data  = 32'h0000_0000;
        imem_ready = 1'b0;

        //                name     word           RegWr      MemRd      MemWr      ctrl3      pc6     h     f
        vecs.push_back(mk("addi",  32'h2009_0005, 6'b001000, 6'b000000, 6'b000000, 6'b010100, 32'd8, 1'b0, 1'b0));
        vecs.push_back(mk("lw",    32'h8C0A_0000, 6'b010000, 6'b011000, 6'b000000, 6'b010101, 32'd4, 1'b0, 1'b0));
        vecs.push_back(mk("sw",    32'hAC0A_0004, 6'b000000, 6'b000000, 6'b001000, 6'b010100, 32'd8, 1'b0, 1'b0));
        vecs.push_back(mk("add",   32'h012A_5820, 6'b001000, 6'b000000, 6'b000000, 6'b100100, 32'd8, 1'b0, 1'b0));
        vecs.push_back(mk("sub",   32'h012A_5822, 6'b001000, 6'b000000, 6'b000000, 6'b101100, 32'd8, 1'b0, 1'b0));
        vecs.push_back(mk("and",   32'h012A_5824, 6'b001000, 6'b000000, 6'b000000, 6'b100000, 32'd8, 1'b0, 1'b0));
        vecs.push_back(mk("or",    32'h012A_5825, 6'b001000, 6'b000000, 6'b000000, 6'b100010, 32'd8, 1'b0, 1'b0));
        vecs.push_back(mk("slt",   32'h012A_582A, 6'b001000, 6'b000000, 6'b000000, 6'b101110, 32'd8, 1'b0, 1'b0));
        vecs.push_back(mk("badfn", 32'h0000_003F, 6'b000000, 6'b000000, 6'b000000, 6'b000100, 32'd4, 1'b1, 1'b1));
        vecs.push_back(mk("halt",  32'hFC00_0000, 6'b000000, 6'b000000, 6'b000000, 6'b000100, 32'd4, 1'b1, 1'b0));
        vecs.push_back(mk("badop", 32'h0800_0000, 6'b000000, 6'b000000, 6'b000000, 6'b000100, 32'd4, 1'b1, 1'b1));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Fetch timeout: 255 cycles without ready, fault visible in cycle 256
        begin
            int   first_fault;
            logic any_en;
            imem_data  = 32'h2009_0005;
            imem_ready = 1'b0;
            first_fault = 0;
            any_en      = 1'b0;
            do_reset();
            for (int c = 1; c <= 300; c++) begin
                if (c > 1) @(negedge clk);
                any_en = any_en | RegWrite | MemWrite | MemRead;
                if (fault && first_fault == 0) first_fault = c;
            end
            chk("timeout cycle",  32'(first_fault), 32'd256);
            chk("timeout halted", 32'(halted),      32'd1);
            chk("timeout req",    32'(imem_req),    32'd0);
            chk("timeout enables",32'(any_en),      32'd0);
            chk("timeout pc",     pc,               32'h0000_0000);
        end

        // Three wait cycles stretch addi to 7 cycles; ready while req=0 is ignored
        begin
            logic [7:0]  rw;
            logic [31:0] pc4, pc5, inst7;
            imem_data  = 32'h2009_0005;
            imem_ready = 1'b0;
            do_reset();
            for (int c = 1; c <= 8; c++) begin
                if (c > 1) @(negedge clk);
                rw[c-1] = RegWrite;
                if (c == 4) begin
                    pc4        = pc;
                    imem_ready = 1'b1;
                end
                if (c == 5) begin
                    pc5       = pc;
                    imem_data = 32'hFFFF_FFFF;
                end
                if (c == 7) inst7 = Inst;
            end
            chk("wait regwrite", 32'(rw), 32'(8'b0100_0000));
            chk("wait pc_c4",    pc4,     32'h0000_0000);
            chk("wait pc_c5",    pc5,     32'h0000_0004);
            chk("wait ir_hold",  inst7,   32'h2009_0005);
        end

        // Reset asserted during MEM of sw aborts the write asynchronously
        begin
            imem_data  = 32'hAC0A_0004;
            imem_ready = 1'b1;
            do_reset();
            repeat (3) @(negedge clk);          // now in cycle 4 (MEM)
            chk("rstmem memwrite_c4", 32'(MemWrite), 32'd1);
            #1 rst_n = 1'b0;
            #1;
            chk("rstmem memwrite_async", 32'(MemWrite), 32'd0);
            chk("rstmem pc_async",       pc,            32'h0000_0000);
            @(negedge clk);
            rst_n = 1'b1;
            chk("rstmem pc",   pc,             32'h0000_0000);
            chk("rstmem req",  32'(imem_req),  32'd1);
            chk("rstmem addr", imem_addr,      32'h0000_0000);
            chk("rstmem ir",   Inst,           32'h0000_0000);
            chk("rstmem halted", 32'(halted),  32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
